// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin, burst-bounded sharing of one FIFO write port among
//            NUM_REQ byte producers; never writes into a full FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic [NUM_REQ-1:0]            grant
);

  localparam int              ID_W      = $clog2(NUM_REQ);
  localparam int              BC_W      = $clog2(MAX_BURST) + 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]         owner_q, owner_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]         beat_q, beat_d;

  logic                    in_grant;
  logic                    own_valid;
  logic                    xfer;
  logic [ID_W-1:0]         next_ptr;
  logic [ID_W-1:0]         cand;
  logic [ID_W-1:0]         pick_id;
  logic                    pick_found;
  logic [DATA_WIDTH-1:0]   din_sel;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    din_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        din_sel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_grant  = (state_q == ST_GRANT);
  assign own_valid = |(req_valid & grant_q);
  assign xfer      = in_grant && own_valid && !fifo_full;
  assign next_ptr  = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;

  assign req_ready  = (in_grant && !fifo_full) ? grant_q : '0;
  assign fifo_wr_en = xfer;
  assign fifo_din   = in_grant ? din_sel : '0;
  assign busy       = in_grant;
  assign owner_id   = owner_q;
  assign grant      = grant_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && pick_found) begin
          state_d          = ST_GRANT;
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          owner_d          = pick_id;
          beat_d           = '0;
        end
      end
      ST_GRANT: begin
        // Owner dropping valid or finishing its burst both rotate the pointer.
        if (!own_valid || (xfer && beat_q == LAST_BEAT)) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed-vector bench for fifo_wr_arbiter (4 requesters, burst 4)
//            plus a 2-requester, burst-1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            arb_en = 1'b0;
  logic            fifo_full = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic            busy;
  logic [1:0]      owner_id;
  logic [NR-1:0]   grant;

  logic [1:0]      b_ready;
  logic            b_wr_en;
  logic [7:0]      b_din;
  logic            b_busy;
  logic [0:0]      b_owner;
  logic [1:0]      b_grant;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy),
    .owner_id(owner_id), .grant(grant)
  );

  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(1)) u_dut_b1 (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(2'b11),
    .req_data(16'hB1A0), .req_ready(b_ready), .fifo_full(1'b0),
    .fifo_wr_en(b_wr_en), .fifo_din(b_din), .busy(b_busy),
    .owner_id(b_owner), .grant(b_grant)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int total[NR];
  int sent[NR];
  int w_cyc[$];
  int w_dat[$];
  int w_own[$];
  int g_id[$];
  int g_cyc[$];
  logic [NR-1:0] prev_grant;
  logic [NR-1:0] s_ready, s_grant;
  logic          s_wren, s_busy;
  logic [1:0]    s1_grant;
  logic          s1_wren;
  logic [7:0]    s1_din;

  int t1c[6]  = '{1, 2, 3, 4, 6, 7};
  int t3c[4]  = '{1, 2, 6, 7};
  int t3bc[4] = '{1, 2, 3, 5};
  int t4c[11] = '{1, 4, 5, 8, 9, 10, 11, 13, 14, 15, 16};
  int t4d[11] = '{'h11, 'h21, 'h22, 'h31, 'h32, 'h33, 'h34, 'h01, 'h02, 'h03, 'h04};
  int t6c[6]  = '{5, 6, 7, 8, 16, 17};
  int t6d[6]  = '{'h01, 'h02, 'h03, 'h04, 'h11, 'h12};
  int t7g[6]  = '{0, 1, 0, 2, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_w(input string tag, input int k, input int c, input int d);
    if (k >= w_cyc.size()) begin
      chk({tag, "_missing"}, 32'(w_cyc.size()), 32'(k + 1));
    end else begin
      chk({tag, "_cyc"}, 32'(w_cyc[k]), 32'(c));
      chk({tag, "_dat"}, 32'(w_dat[k]), 32'(d));
    end
  endtask

  task automatic chk_g(input string tag, input int k, input int id, input int c);
    if (k >= g_id.size()) begin
      chk({tag, "_missing"}, 32'(g_id.size()), 32'(k + 1));
    end else begin
      chk({tag, "_id"}, 32'(g_id[k]), 32'(id));
      chk({tag, "_cyc"}, 32'(g_cyc[k]), 32'(c));
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = (sent[i] < total[i]);
      req_data[i*DW +: DW]  = DW'((i << 4) + sent[i] + 1);
    end
  endtask

  task automatic clear_logs();
    w_cyc.delete(); w_dat.delete(); w_own.delete();
    g_id.delete(); g_cyc.delete();
    prev_grant = '0;
    cyc = 0;
  endtask

  // Sample one cycle at the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    s_ready = req_ready; s_wren = fifo_wr_en; s_busy = busy; s_grant = grant;
    s1_grant = b_grant; s1_wren = b_wr_en; s1_din = b_din;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    chk("wr_while_full", 32'(fifo_wr_en & fifo_full), 32'd0);
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) sent[i]++;
    end
    if (fifo_wr_en) begin
      w_cyc.push_back(cyc); w_dat.push_back(int'(fifo_din)); w_own.push_back(int'(owner_id));
    end
    if (grant != '0 && prev_grant == '0) begin
      g_id.push_back(int'(owner_id)); g_cyc.push_back(cyc);
    end
    prev_grant = grant;
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; arb_en = 1'b1; fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin total[i] = 0; sent[i] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin total[i] = 1; sent[i] = 0; end
    arb_en = 1'b1;
    drive();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_owner", 32'(owner_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wren", 32'(fifo_wr_en), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single requester, six beats: burst of four, dead cycle, re-grant.
    reset_dut();
    total[0] = 6; drive();
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) chk("t1_grant_c0", 32'(s_grant), 32'd0);
      if (c == 1) chk("t1_grant_c1", 32'(s_grant), 32'b0001);
      if (c == 5) chk("t1_dead_busy", 32'(s_busy), 32'd0);
    end
    chk("t1_nwr", 32'(w_cyc.size()), 32'd6);
    for (int k = 0; k < 6; k++) chk_w("t1_wr", k, t1c[k], k + 1);
    for (int k = 0; k < w_own.size(); k++) chk("t1_owner", 32'(w_own[k]), 32'd0);
    chk_g("t1_g0", 0, 0, 1);
    chk_g("t1_g1", 1, 0, 6);

    // All four requesters continuously valid.
    reset_dut();
    for (int i = 0; i < NR; i++) total[i] = 100;
    drive();
    repeat (25) step();
    chk("t2_nwr", 32'(w_cyc.size()), 32'd20);
    for (int k = 0; k < 20; k++) begin
      chk_w("t2_wr", k, (k / 4) * 5 + 1 + (k % 4),
            (((k / 4) % 4) << 4) + ((k / 16) * 4) + (k % 4) + 1);
    end
    for (int b = 0; b < 5; b++) chk_g("t2_g", b, b % 4, b * 5 + 1);

    // Requester 1 stalled by fifo_full for three cycles after beat 2.
    reset_dut();
    total[1] = 4; drive();
    for (int c = 0; c < 10; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      step();
      if (c >= 3 && c <= 5) begin
        chk("t3_ready_stall", 32'(s_ready), 32'd0);
        chk("t3_wren_stall", 32'(s_wren), 32'd0);
        chk("t3_grant_hold", 32'(s_grant), 32'b0010);
      end
    end
    fifo_full = 1'b0;
    chk("t3_nwr", 32'(w_cyc.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk_w("t3_wr", k, t3c[k], 'h11 + k);

    // fifo_full in the same cycle as the final beat blocks that beat.
    reset_dut();
    total[1] = 4; drive();
    for (int c = 0; c < 8; c++) begin
      fifo_full = (c == 4);
      step();
    end
    fifo_full = 1'b0;
    chk("t3b_nwr", 32'(w_cyc.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk_w("t3b_wr", k, t3bc[k], 'h11 + k);

    // Requester 2 drops after two beats; pointer moves to 3, not 0.
    reset_dut();
    total[1] = 1; total[2] = 2; total[3] = 4; drive();
    for (int c = 0; c < 18; c++) begin
      if (c == 3) begin total[0] = 4; drive(); end
      step();
    end
    chk("t4_nwr", 32'(w_cyc.size()), 32'd11);
    for (int k = 0; k < 11; k++) chk_w("t4_wr", k, t4c[k], t4d[k]);
    chk_g("t4_g0", 0, 1, 1);
    chk_g("t4_g1", 1, 2, 4);
    chk_g("t4_g2", 2, 3, 8);
    chk_g("t4_g3", 3, 0, 13);

    // Asynchronous reset during requester 1's burst.
    reset_dut();
    for (int i = 0; i < NR; i++) total[i] = 100;
    drive();
    repeat (8) step();
    chk("t5_pre_wren", 32'(fifo_wr_en), 32'd1);
    chk("t5_pre_grant", 32'(grant), 32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_wren", 32'(fifo_wr_en), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_owner", 32'(owner_id), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    repeat (3) step();
    chk_g("t5_first", 0, 0, 1);

    // arb_en gating: no grant while low; a running burst still completes.
    reset_dut();
    for (int i = 0; i < NR; i++) total[i] = 4;
    drive();
    for (int c = 0; c < 18; c++) begin
      arb_en = (c >= 4 && c < 6) || (c >= 15);
      step();
      if (c < 4) chk("t6_nogrant", 32'(s_grant), 32'd0);
      if (c >= 9 && c <= 14) chk("t6_idle_busy", 32'(s_busy), 32'd0);
    end
    chk("t6_nwr", 32'(w_cyc.size()), 32'd6);
    for (int k = 0; k < 6; k++) chk_w("t6_wr", k, t6c[k], t6d[k]);
    chk_g("t6_g0", 0, 0, 5);
    chk_g("t6_g1", 1, 1, 16);

    // MAX_BURST=1: rotation after every single beat.
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t7_grant", 32'(s1_grant), 32'(t7g[c]));
      if (c == 1) chk("t7_din0", 32'(s1_din), 32'hA0);
      if (c == 3) chk("t7_din1", 32'(s1_din), 32'hB1);
      if (c == 2) chk("t7_dead_wren", 32'(s1_wren), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
